// File: rtl/otter_crypto_pkg.sv
// Shared types and helper functions for the OTTER ENCRY Feistel engine.
// Holds the FSM state type, the round function and the round-key schedule.
package otter_crypto_pkg;

  localparam int unsigned CRY_ROUNDS_MAX   = 16;
  localparam int unsigned CRY_ROT_STEP_DEF = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } crypto_state_t;

  // F(R,k) = (rotl16(R,3) + k) ^ (R >> 2), add wraps modulo 2^16.
  function automatic logic [15:0] crypto_f(logic [15:0] r, logic [15:0] k);
    logic [15:0] rot;
    rot = {r[12:0], r[15:13]};
    return (rot + k) ^ (r >> 2);
  endfunction

  // K_idx = rotl32(key, (rot_step*idx) mod 32).
  function automatic logic [31:0] round_key(logic [31:0] key, int unsigned idx,
                                            int unsigned rot_step = CRY_ROT_STEP_DEF);
    int unsigned amt;
    logic [63:0] dbl;
    amt = (rot_step * idx) % 32;
    dbl = {key, key} << amt;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/otter_crypto_if.sv
// Request/response bundle between the OTTER control unit and the crypto engine.
// The CU side is the master; the engine is the slave.
interface otter_crypto_if;

  logic        cry_start;
  logic        cry_decrypt;
  logic [31:0] cry_data_in;
  logic [31:0] cry_key;
  logic        cry_busy;
  logic        cry_done;
  logic [31:0] cry_result;

  modport master (
    output cry_start,
    output cry_decrypt,
    output cry_data_in,
    output cry_key,
    input  cry_busy,
    input  cry_done,
    input  cry_result
  );

  modport slave (
    input  cry_start,
    input  cry_decrypt,
    input  cry_data_in,
    input  cry_key,
    output cry_busy,
    output cry_done,
    output cry_result
  );

endinterface

// File: rtl/crypto_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R, k).
module crypto_round
  import otter_crypto_pkg::*;
(
  input  logic [15:0] l_i,
  input  logic [15:0] r_i,
  input  logic [15:0] k_i,
  output logic [15:0] l_o,
  output logic [15:0] r_o
);

  always_comb begin
    l_o = r_i;
    r_o = l_i ^ crypto_f(r_i, k_i);
  end

endmodule

// File: rtl/otter_crypto_engine.sv
// Iterative 32-bit Feistel engine for the ENCRY opcode: one round per clock,
// a one-cycle done pulse, and a result register held until the next accepted start.
module otter_crypto_engine
  import otter_crypto_pkg::*;
#(
  parameter int unsigned ROUNDS   = 8,
  parameter int unsigned ROT_STEP = 5
) (
  input  logic           CRY_CLK,
  input  logic           CRY_RESET,
  otter_crypto_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ROUNDS + 1);

  crypto_state_t state_q, state_d;
  logic [CntW-1:0] rnd_q, rnd_d;
  logic [15:0]     l_q, l_d;
  logic [15:0]     r_q, r_d;
  logic [31:0]     key_q, key_d;
  logic            dec_q, dec_d;
  logic [31:0]     result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [15:0]     l_nxt, r_nxt;
  logic [31:0]     rkey;
  logic [15:0]     rkey_lo;
  int unsigned     key_idx;

  // Decrypt walks the key schedule backwards.
  always_comb begin
    key_idx = dec_q ? (ROUNDS - 1 - 32'(rnd_q)) : 32'(rnd_q);
    rkey    = round_key(key_q, key_idx, ROT_STEP);
    rkey_lo = rkey[15:0];
  end

  crypto_round u_round (
    .l_i (l_q),
    .r_i (r_q),
    .k_i (rkey_lo),
    .l_o (l_nxt),
    .r_o (r_nxt)
  );

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    l_d      = l_q;
    r_d      = r_q;
    key_d    = key_q;
    dec_d    = dec_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cry_start) begin
          l_d     = bus.cry_data_in[31:16];
          r_d     = bus.cry_data_in[15:0];
          key_d   = bus.cry_key;
          dec_d   = bus.cry_decrypt;
          rnd_d   = '0;
          busy_d  = 1'b1;
          state_d = StRound;
        end
      end
      StRound: begin
        l_d   = l_nxt;
        r_d   = r_nxt;
        rnd_d = rnd_q + CntW'(1);
        if (rnd_q == CntW'(ROUNDS - 1)) begin
          // Output swap makes decrypt the exact inverse of encrypt.
          result_d = {r_nxt, l_nxt};
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CRY_CLK) begin
    if (CRY_RESET) begin
      state_q  <= StIdle;
      rnd_q    <= '0;
      l_q      <= '0;
      r_q      <= '0;
      key_q    <= '0;
      dec_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      l_q      <= l_d;
      r_q      <= r_d;
      key_q    <= key_d;
      dec_q    <= dec_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.cry_busy   = busy_q;
  assign bus.cry_done   = done_q;
  assign bus.cry_result = result_q;

endmodule

// File: tb/tb_otter_crypto_engine.sv
// Scoreboard bench for otter_crypto_engine at ROUNDS = 8, 1 and 16.
// Expected results come from an independent bench-side cipher model.
module tb_otter_crypto_engine;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  otter_crypto_if bus0 ();
  otter_crypto_if bus1 ();
  otter_crypto_if bus2 ();

  logic        start_r  [3];
  logic        dec_r    [3];
  logic [31:0] data_r   [3];
  logic [31:0] key_r    [3];
  logic        busy_w   [3];
  logic        done_w   [3];
  logic [31:0] result_w [3];

  assign bus0.cry_start   = start_r[0];
  assign bus0.cry_decrypt = dec_r[0];
  assign bus0.cry_data_in = data_r[0];
  assign bus0.cry_key     = key_r[0];
  assign busy_w[0]        = bus0.cry_busy;
  assign done_w[0]        = bus0.cry_done;
  assign result_w[0]      = bus0.cry_result;

  assign bus1.cry_start   = start_r[1];
  assign bus1.cry_decrypt = dec_r[1];
  assign bus1.cry_data_in = data_r[1];
  assign bus1.cry_key     = key_r[1];
  assign busy_w[1]        = bus1.cry_busy;
  assign done_w[1]        = bus1.cry_done;
  assign result_w[1]      = bus1.cry_result;

  assign bus2.cry_start   = start_r[2];
  assign bus2.cry_decrypt = dec_r[2];
  assign bus2.cry_data_in = data_r[2];
  assign bus2.cry_key     = key_r[2];
  assign busy_w[2]        = bus2.cry_busy;
  assign done_w[2]        = bus2.cry_done;
  assign result_w[2]      = bus2.cry_result;

  otter_crypto_engine #(.ROUNDS(8), .ROT_STEP(5)) u_dut8 (
    .CRY_CLK   (clk),
    .CRY_RESET (rst),
    .bus       (bus0)
  );

  otter_crypto_engine #(.ROUNDS(1), .ROT_STEP(5)) u_dut1 (
    .CRY_CLK   (clk),
    .CRY_RESET (rst),
    .bus       (bus1)
  );

  otter_crypto_engine #(.ROUNDS(16), .ROT_STEP(5)) u_dut16 (
    .CRY_CLK   (clk),
    .CRY_RESET (rst),
    .bus       (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  logic [31:0] sb2 [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rounds_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 1 : 16);
  endfunction

  // Bench-side reference model, written independently of the RTL package.
  function automatic logic [15:0] m_f(input logic [15:0] r, input logic [15:0] k);
    logic [15:0] rot;
    rot = (r << 3) | (r >> 13);
    return (rot + k) ^ {2'b00, r[15:2]};
  endfunction

  function automatic logic [31:0] m_key(input logic [31:0] key, input int unsigned idx);
    logic [31:0] kk;
    kk = key;
    for (int s = 0; s < int'((5 * idx) % 32); s++) kk = {kk[30:0], kk[31]};
    return kk;
  endfunction

  function automatic logic [31:0] m_crypt(input int unsigned rounds, input logic dec,
                                          input logic [31:0] data, input logic [31:0] key);
    logic [15:0] l, r, t;
    logic [31:0] kf;
    int unsigned j;
    l = data[31:16];
    r = data[15:0];
    for (int unsigned i = 0; i < rounds; i++) begin
      j  = dec ? (rounds - 1 - i) : i;
      kf = m_key(key, j);
      t  = r;
      r  = l ^ m_f(r, kf[15:0]);
      l  = t;
    end
    return {r, l};
  endfunction

  task automatic sb_push(input int i, input logic [31:0] v);
    case (i)
      0:       sb0.push_back(v);
      1:       sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int i);
    logic [31:0] e;
    int          sz;
    sz = (i == 0) ? sb0.size() : ((i == 1) ? sb1.size() : sb2.size());
    if (sz == 0) begin
      check_eq($sformatf("spurious_done%0d", i), {31'b0, done_w[i]}, 32'h0);
    end else begin
      case (i)
        0:       e = sb0.pop_front();
        1:       e = sb1.pop_front();
        default: e = sb2.pop_front();
      endcase
      check_eq($sformatf("sb_result%0d", i), result_w[i], e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (done_w[i] === 1'b1) sb_pop(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic dec, input logic [31:0] d, input logic [31:0] k);
    dec_r[i]   = dec;
    data_r[i]  = d;
    key_r[i]   = k;
    start_r[i] = 1'b1;
    tick();
    start_r[i] = 1'b0;
  endtask

  // Returns the start-to-done cycle count and number of busy cycles; leaves the DUT in IDLE.
  task automatic wait_done(input int i, output int cyc, output int bcnt, output logic [31:0] res);
    bit got;
    got  = 1'b0;
    cyc  = 1;
    bcnt = 0;
    res  = '0;
    for (int t = 0; t < int'(rounds_of(i)) + 6; t++) begin
      @(negedge clk);
      if (busy_w[i]) bcnt++;
      if (done_w[i]) begin
        res = result_w[i];
        got = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    if (!got) check_eq($sformatf("done_timeout%0d", i), {31'b0, done_w[i]}, 32'h1);
    tick();
  endtask

  initial begin
    int          cyc, bcnt, ndone;
    logic [31:0] res, a, b, d, k;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      dec_r[i]   = 1'b0;
      data_r[i]  = '0;
      key_r[i]   = '0;
    end

    // Reset held two cycles with START high: it must be ignored.
    start_r[0] = 1'b1;
    data_r[0]  = 32'h1234_5678;
    tick();
    tick();
    check_eq("rst_busy", {31'b0, busy_w[0]}, 32'h0);
    check_eq("rst_done", {31'b0, done_w[0]}, 32'h0);
    check_eq("rst_result", result_w[0], 32'h0);
    rst        = 1'b0;
    start_r[0] = 1'b0;
    tick();
    check_eq("rst_start_dropped", {31'b0, busy_w[0]}, 32'h0);

    // Zero vector plus latency and busy-width checks.
    sb_push(0, m_crypt(8, 1'b0, 32'h0, 32'h0));
    issue(0, 1'b0, 32'h0, 32'h0);
    wait_done(0, cyc, bcnt, res);
    check_eq("zero_result", res, 32'h0);
    check_eq("zero_latency", cyc, 32'd9);
    check_eq("zero_busy_cycles", bcnt, 32'd9);

    // Directed round trip.
    sb_push(0, m_crypt(8, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567));
    issue(0, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567);
    wait_done(0, cyc, bcnt, res);
    sb_push(0, 32'hDEAD_BEEF);
    issue(0, 1'b1, res, 32'h0123_4567);
    wait_done(0, cyc, bcnt, res);
    check_eq("roundtrip_deadbeef", res, 32'hDEAD_BEEF);

    // Random round trips spread across the three ROUNDS settings.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 334; n++) begin
        d = $urandom;
        k = $urandom;
        sb_push(i, m_crypt(rounds_of(i), 1'b0, d, k));
        issue(i, 1'b0, d, k);
        wait_done(i, cyc, bcnt, res);
        sb_push(i, d);
        issue(i, 1'b1, res, k);
        wait_done(i, cyc, bcnt, res);
        if (n == 0) check_eq($sformatf("latency%0d", i), cyc, rounds_of(i) + 1);
      end
    end

    // START pulses while busy must not be captured or queued.
    a = 32'hA5A5_0F0F;
    b = 32'h5A5A_F0F0;
    sb_push(0, m_crypt(8, 1'b0, a, 32'hCAFE_F00D));
    issue(0, 1'b0, a, 32'hCAFE_F00D);
    ndone = 0;
    for (int c = 1; c <= 8 + 4; c++) begin
      start_r[0] = (c == 3) || (c == 8 + 1);
      data_r[0]  = b;
      key_r[0]   = 32'h1111_2222;
      @(negedge clk);
      if (done_w[0]) ndone++;
      tick();
    end
    start_r[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_w[0]) ndone++;
      tick();
    end
    check_eq("busy_start_ndone", ndone, 32'd1);
    check_eq("busy_start_result", result_w[0], m_crypt(8, 1'b0, a, 32'hCAFE_F00D));

    // Reset mid-operation drops the op without a DONE.
    issue(0, 1'b0, 32'h0BAD_CAFE, 32'h7777_8888);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", {31'b0, busy_w[0]}, 32'h0);
    check_eq("midrst_result", result_w[0], 32'h0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_w[0]) ndone++;
      tick();
    end
    check_eq("midrst_ndone", ndone, 32'd0);
    sb_push(0, m_crypt(8, 1'b0, 32'h0BAD_CAFE, 32'h7777_8888));
    issue(0, 1'b0, 32'h0BAD_CAFE, 32'h7777_8888);
    wait_done(0, cyc, bcnt, res);
    check_eq("midrst_recover", res, m_crypt(8, 1'b0, 32'h0BAD_CAFE, 32'h7777_8888));

    // Inputs scrambled every cycle after capture, for both directions.
    for (int dir = 0; dir < 2; dir++) begin
      d = $urandom;
      k = $urandom;
      sb_push(0, m_crypt(8, dir[0], d, k));
      issue(0, dir[0], d, k);
      ndone = 0;
      for (int c = 0; c < 14; c++) begin
        dec_r[0]  = 1'($urandom);
        data_r[0] = $urandom;
        key_r[0]  = $urandom;
        @(negedge clk);
        if (done_w[0]) ndone++;
        tick();
      end
      check_eq($sformatf("hold_ndone%0d", dir), ndone, 32'd1);
      check_eq($sformatf("hold_result%0d", dir), result_w[0], m_crypt(8, dir[0], d, k));
    end

    tick();
    check_eq("sb0_left", sb0.size(), 32'd0);
    check_eq("sb1_left", sb1.size(), 32'd0);
    check_eq("sb2_left", sb2.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
